// File: rtl/ballplayer_pkg.sv
// Shared constants for the ball game speed path: clock/rate defaults, level width,
// and the period helper used by the pacer (the key adjuster shares LVL_W).
// Purely elaboration-time content; no logic.
package ballplayer_pkg;

  localparam int unsigned CLK_HZ_DEF    = 12_000_000;
  localparam int unsigned RATE_UNIT_DEF = 10;
  localparam int unsigned LVL_W         = 2;

  // Cycles per step at level k: step rate is (k+5)*unit Hz, floor division.
  function automatic int unsigned speed_period(input int unsigned k,
                                               input int unsigned clk_hz,
                                               input int unsigned unit);
    return clk_hz / ((k + 5) * unit);
  endfunction

endpackage

// File: rtl/ball_pacer.sv
// Ball pacer: turns speed level k into one-cycle step pulses, one per P[k_applied] cycles.
// Latency: first step P[k_applied] cycles after run rises; level changes apply at the next step boundary.
// No backpressure; optional freeze input `pause` exists only when PACER_PAUSE_EN is defined.
module ball_pacer
  import ballplayer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
  parameter int unsigned RATE_UNIT = RATE_UNIT_DEF,
  parameter int unsigned CNT_W     = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] k,
  input  logic             run,
`ifdef PACER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             step,
  output logic [LVL_W-1:0] k_applied,
  output logic [7:0]       step_cnt
);

  // Terminal counts (P-1) for each level, fixed at elaboration.
  localparam logic [CNT_W-1:0] TERM0 = CNT_W'(speed_period(0, CLK_HZ, RATE_UNIT) - 1);
  localparam logic [CNT_W-1:0] TERM1 = CNT_W'(speed_period(1, CLK_HZ, RATE_UNIT) - 1);
  localparam logic [CNT_W-1:0] TERM2 = CNT_W'(speed_period(2, CLK_HZ, RATE_UNIT) - 1);
  localparam logic [CNT_W-1:0] TERM3 = CNT_W'(speed_period(3, CLK_HZ, RATE_UNIT) - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;
  logic             hold;

`ifdef PACER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Select the terminal count for the level currently in force.
  always_comb begin
    term = TERM0;
    case (k_applied)
      2'd0:    term = TERM0;
      2'd1:    term = TERM1;
      2'd2:    term = TERM2;
      default: term = TERM3;
    endcase
  end

  // Period counter, step pulse, step count and applied level; run=0 overrides everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      step      <= 1'b0;
      k_applied <= '0;
      step_cnt  <= '0;
    end else if (!run) begin
      cnt       <= '0;
      step      <= 1'b0;
      step_cnt  <= '0;
      k_applied <= k;
    end else if (hold) begin
      step      <= 1'b0;
    end else if (cnt == term) begin
      cnt       <= '0;
      step      <= 1'b1;
      step_cnt  <= step_cnt + 8'd1;
      k_applied <= k;
    end else begin
      cnt       <= cnt + 1'b1;
      step      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ball_pacer.sv
// Directed bench for ball_pacer at CLK_HZ=1200, RATE_UNIT=10 (P = 24, 20, 17, 15).
// Inputs change 1 ns after posedge; outputs are checked there too, well clear of the next edge.
// Pause scenario is included only when PACER_PAUSE_EN is defined.
module tb_ball_pacer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] k   = 2'd0;
  logic       run = 1'b0;
`ifdef PACER_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       step;
  logic [1:0] k_applied;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;
  int n;
  int nsteps;

  ball_pacer #(.CLK_HZ(1200), .RATE_UNIT(10), .CNT_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .k         (k),
    .run       (run),
`ifdef PACER_PAUSE_EN
    .pause     (pause),
`endif
    .step      (step),
    .k_applied (k_applied),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Cycles from now until step is seen high; bounded so a dead DUT cannot hang the run.
  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (step !== 1'b1 && cycles < 400);
  endtask

  initial begin
    // 1. Reset and idle
    rst = 1'b0; run = 1'b0; k = 2'd2;
    tick(3);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_k_applied", {30'd0, k_applied}, 32'd0);
    chk("rst_step_cnt", {24'd0, step_cnt}, 32'd0);
    rst = 1'b1;
    tick(1);
    chk("idle_k_applied", {30'd0, k_applied}, 32'd2);
    chk("idle_step_cnt", {24'd0, step_cnt}, 32'd0);
    nsteps = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (step === 1'b1) nsteps++;
    end
    chk("idle_no_steps", nsteps, 0);

    // 2. Level 0 pacing
    k = 2'd0;
    tick(1);
    run = 1'b1;
    wait_step(n);
    chk("l0_first_gap", n, 24);
    chk("l0_cnt1", {24'd0, step_cnt}, 32'd1);
    tick(1);
    chk("l0_pulse_width", {31'd0, step}, 32'd0);
    wait_step(n);
    chk("l0_gap2", n, 23);
    chk("l0_cnt2", {24'd0, step_cnt}, 32'd2);
    wait_step(n);
    chk("l0_gap3", n, 24);
    chk("l0_cnt3", {24'd0, step_cnt}, 32'd3);

    // 3. Mid-period level change: current period finishes at old rate
    tick(10);
    k = 2'd3;
    tick(1);
    chk("mid_k_held", {30'd0, k_applied}, 32'd0);
    chk("mid_cnt_held", {24'd0, step_cnt}, 32'd3);
    wait_step(n);
    chk("mid_old_gap", n, 13);
    chk("mid_k_applied3", {30'd0, k_applied}, 32'd3);
    wait_step(n);
    chk("mid_new_gap", n, 15);
    // Several changes in one period: only the boundary value counts
    tick(3);
    k = 2'd1;
    tick(3);
    k = 2'd2;
    wait_step(n);
    chk("multi_gap", n, 9);
    chk("multi_k_applied", {30'd0, k_applied}, 32'd2);
    wait_step(n);
    chk("multi_new_gap", n, 17);

    // 4. run drops on the terminal cycle
    run = 1'b0; k = 2'd0;
    tick(2);
    chk("stop_step_cnt", {24'd0, step_cnt}, 32'd0);
    chk("stop_k_applied", {30'd0, k_applied}, 32'd0);
    run = 1'b1;
    tick(23);
    run = 1'b0;
    tick(1);
    chk("term_drop_step", {31'd0, step}, 32'd0);
    chk("term_drop_cnt", {24'd0, step_cnt}, 32'd0);
    run = 1'b1;
    wait_step(n);
    chk("rerun_gap", n, 24);
    chk("rerun_cnt", {24'd0, step_cnt}, 32'd1);

    // 5. Wrap of step_cnt at level 3, then asynchronous reset
    run = 1'b0; k = 2'd3;
    tick(1);
    run = 1'b1;
    for (int i = 0; i < 255; i++) begin
      wait_step(n);
      chk("wrap_gap", n, 15);
    end
    chk("wrap_cnt255", {24'd0, step_cnt}, 32'd255);
    wait_step(n);
    chk("wrap_last_gap", n, 15);
    chk("wrap_cnt0", {24'd0, step_cnt}, 32'd0);
    wait_step(n);
    chk("wrap_cnt1", {24'd0, step_cnt}, 32'd1);
    chk("pre_arst_step", {31'd0, step}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_step", {31'd0, step}, 32'd0);
    chk("arst_step_cnt", {24'd0, step_cnt}, 32'd0);
    chk("arst_k_applied", {30'd0, k_applied}, 32'd0);
    tick(2);
    rst = 1'b1;

`ifdef PACER_PAUSE_EN
    // 6. Pause holds the count; the period resumes with its remaining cycles
    run = 1'b0; k = 2'd1;
    tick(1);
    run = 1'b1;
    tick(8);
    pause = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (step === 1'b1) nsteps++;
    end
    chk("pause_no_steps", nsteps, 0);
    chk("pause_step_cnt", {24'd0, step_cnt}, 32'd0);
    pause = 1'b0;
    wait_step(n);
    chk("pause_resume_gap", n, 12);
    chk("pause_resume_cnt", {24'd0, step_cnt}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
